// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 32 x 64-bit register file write/read slice.
// Consumers: regfile_write_decoder, decoder5_32, regfile_write_decoder_if.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_IDX = 31;

    typedef logic [ADDR_W-1:0]   reg_idx_t;
    typedef logic [DATA_W-1:0]   reg_word_t;
    typedef logic [NUM_REGS-1:0] onehot_t;

endpackage

// File: rtl/regfile_write_decoder_if.sv
// Write/read bus between the pipeline (master) and the register file (slave).
interface regfile_write_decoder_if;
    import regfile_pkg::*;

    logic      RegWrite;
    reg_idx_t  WriteRegister;
    reg_word_t WriteData;
    reg_idx_t  ReadRegister1;
    reg_idx_t  ReadRegister2;
    reg_word_t ReadData1;
    reg_word_t ReadData2;
    onehot_t   wr_onehot;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, wr_onehot
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, wr_onehot
    );

endinterface

// File: rtl/regfile_write_decoder_decoder5_32.sv
// Enable-gated 5-to-32 one-hot decoder: a 2-to-4 stage selects one of four 3-to-8 stages.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic     i_en,
    input  reg_idx_t i_idx,
    output onehot_t  o_onehot
);

    logic [3:0] w_hi;

    // AND-gating keeps an unknown index from leaking through while disabled
    for (genvar k = 0; k < 4; k++) begin : g_hi
        assign w_hi[k] = i_en & (i_idx[4:3] == 2'(k));
        for (genvar j = 0; j < 8; j++) begin : g_lo
            assign o_onehot[8*k + j] = w_hi[k] & (i_idx[2:0] == 3'(j));
        end
    end

endmodule

// File: rtl/regfile_write_decoder.sv
// 32 x 64-bit register file: one decoded write port, two combinational read ports, X31 reads zero.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_write_decoder
    import regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_decoder_if.slave  bus
);

    localparam reg_idx_t ZERO_SEL = reg_idx_t'(ZERO_IDX);

    onehot_t   w_dec;
    onehot_t   w_onehot;
    reg_word_t r_regs [NUM_REGS];
    reg_word_t w_rd1;
    reg_word_t w_rd2;

    decoder5_32 u_dec (
        .i_en     (bus.RegWrite),
        .i_idx    (bus.WriteRegister),
        .o_onehot (w_dec)
    );

    assign w_onehot = w_dec & ~(onehot_t'(1) << ZERO_IDX);

    // Storage: reset wins over a coincident write; the zero slot is never enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_onehot[i]) begin
                    r_regs[i] <= bus.WriteData;
                end
            end
        end
    end

    // Read selectors; the zero index is excluded so it reads 0 even before the first reset
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i != ZERO_IDX) begin
                if (bus.ReadRegister1 == ADDR_W'(i)) begin
                    w_rd1 = r_regs[i];
                end
                if (bus.ReadRegister2 == ADDR_W'(i)) begin
                    w_rd2 = r_regs[i];
                end
            end
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (bus.RegWrite && (bus.WriteRegister != ZERO_SEL)) begin
            if (bus.ReadRegister1 == bus.WriteRegister) begin
                w_rd1 = bus.WriteData;
            end
            if (bus.ReadRegister2 == bus.WriteRegister) begin
                w_rd2 = bus.WriteData;
            end
        end
`else
        w_rd1 = (bus.ReadRegister1 == ZERO_SEL) ? '0 : w_rd1;
        w_rd2 = (bus.ReadRegister2 == ZERO_SEL) ? '0 : w_rd2;
`endif
        if (reset) begin
            w_rd1 = '0;
            w_rd2 = '0;
        end
    end

    assign bus.ReadData1 = w_rd1;
    assign bus.ReadData2 = w_rd2;
    assign bus.wr_onehot = w_onehot;

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Directed, table-driven self-checking bench for regfile_write_decoder.
module tb_regfile_write_decoder;
    import regfile_pkg::*;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic      rst;
        logic      we;
        reg_idx_t  wa;
        reg_word_t wd;
        reg_idx_t  ra1;
        reg_idx_t  ra2;
        reg_word_t e1;
        reg_word_t e2;
        onehot_t   eoh;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    regfile_write_decoder_if bus ();

    regfile_write_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic we, int wa, reg_word_t wd, int ra1, int ra2,
                                reg_word_t e1, reg_word_t e2, onehot_t eoh);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = reg_idx_t'(wa); v.wd = wd;
        v.ra1 = reg_idx_t'(ra1); v.ra2 = reg_idx_t'(ra2);
        v.e1 = e1; v.e2 = e2; v.eoh = eoh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input int wa, input reg_word_t wd,
                         input int ra1, input int ra2);
        reset             = rst;
        bus.RegWrite      = we;
        bus.WriteRegister = reg_idx_t'(wa);
        bus.WriteData     = wd;
        bus.ReadRegister1 = reg_idx_t'(ra1);
        bus.ReadRegister2 = reg_idx_t'(ra2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t v [13];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Expected outputs are observed before the edge that applies each row
        v[0]  = mk(1, 0,  0, 64'h0,                    0,  0, 64'h0, 64'h0, 32'h0);
        v[1]  = mk(1, 1,  5, 64'h1111,                 5,  5, 64'h0, 64'h0, 32'h0000_0020);
        v[2]  = mk(0, 1,  5, 64'hDEADBEEF_CAFEF00D,    0,  6, 64'h0, 64'h0, 32'h0000_0020);
        v[3]  = mk(0, 0,  5, 64'h0,                    5,  6, 64'hDEADBEEF_CAFEF00D, 64'h0, 32'h0);
        v[4]  = mk(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31,  5, 64'h0, 64'hDEADBEEF_CAFEF00D, 32'h0);
        v[5]  = mk(0, 0, 31, 64'h0,                   31, 31, 64'h0, 64'h0, 32'h0);
        v[6]  = mk(0, 1,  3, 64'h1234,                 0,  0, 64'h0, 64'h0, 32'h0000_0008);
        v[7]  = mk(0, 0,  3, 64'h9999,                 3,  3, 64'h1234, 64'h1234, 32'h0);
        v[8]  = mk(0, 1,  3, 64'h9999,                 3,  5, BYP ? 64'h9999 : 64'h1234,
                   64'hDEADBEEF_CAFEF00D, 32'h0000_0008);
        v[9]  = mk(0, 0,  3, 64'h0,                    3,  3, 64'h9999, 64'h9999, 32'h0);
        v[10] = mk(0, 1, 10, 64'h1111,                 0,  0, 64'h0, 64'h0, 32'h0000_0400);
        v[11] = mk(0, 1, 10, 64'h2222,                 0,  0, 64'h0, 64'h0, 32'h0000_0400);
        v[12] = mk(0, 0, 10, 64'h0,                   10, 10, 64'h2222, 64'h2222, 32'h0);

        // Reset held two cycles, then every index reads zero on both ports
        drive(1, 0, 0, 64'h0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 64'h0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            bus.ReadRegister1 = reg_idx_t'(i);
            bus.ReadRegister2 = reg_idx_t'(31 - i);
            #1;
            chk($sformatf("rst_rd1[%0d]", i), bus.ReadData1, 64'h0);
            chk($sformatf("rst_rd2[%0d]", 31 - i), bus.ReadData2, 64'h0);
        end
        chk("rst_onehot", 64'(bus.wr_onehot), 64'h0);
        step();

        for (int i = 0; i < 13; i++) begin
            drive(v[i].rst, v[i].we, int'(v[i].wa), v[i].wd, int'(v[i].ra1), int'(v[i].ra2));
            #2;
            chk($sformatf("vec%0d_rd1", i), bus.ReadData1, v[i].e1);
            chk($sformatf("vec%0d_rd2", i), bus.ReadData2, v[i].e2);
            chk($sformatf("vec%0d_onehot", i), 64'(bus.wr_onehot), 64'(v[i].eoh));
            step();
        end

        // Sweep: write i*0x0101 to every writable index on consecutive cycles
        for (int i = 0; i < 31; i++) begin
            drive(0, 1, i, 64'(i) * 64'h0101, 31, 31);
            #2;
            chk($sformatf("sweep_onehot[%0d]", i), 64'(bus.wr_onehot), 64'h1 << i);
            step();
        end
        drive(0, 0, 0, 64'h0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            bus.ReadRegister1 = reg_idx_t'(i);
            bus.ReadRegister2 = reg_idx_t'(31 - i);
            #1;
            chk($sformatf("sweep_rd1[%0d]", i), bus.ReadData1,
                (i == 31) ? 64'h0 : 64'(i) * 64'h0101);
            chk($sformatf("sweep_rd2[%0d]", 31 - i), bus.ReadData2,
                (i == 0) ? 64'h0 : 64'(31 - i) * 64'h0101);
        end
        step();

        // Disabled write with an unknown index must leave storage intact
        drive(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 30);
        bus.WriteRegister = 'x;
        #2;
        chk("xidx_onehot", 64'(bus.wr_onehot), 64'h0);
        step();
        #1;
        chk("xidx_rd1", bus.ReadData1, 64'h0);
        chk("xidx_rd2", bus.ReadData2, 64'd30 * 64'h0101);

        // Reset on the same edge as a write to R7: reset wins, all state lost
        drive(1, 1, 7, 64'hAA, 7, 20);
        #2;
        chk("race_onehot", 64'(bus.wr_onehot), 64'h80);
        chk("race_rd1_during", bus.ReadData1, 64'h0);
        step();
        drive(0, 0, 7, 64'h0, 7, 20);
        #2;
        chk("race_r7", bus.ReadData1, 64'h0);
        chk("race_r20", bus.ReadData2, 64'h0);
        step();
        drive(0, 1, 7, 64'h55, 0, 0);
        step();
        drive(0, 0, 0, 64'h0, 7, 7);
        #2;
        chk("resume_rd1", bus.ReadData1, 64'h55);
        chk("resume_rd2", bus.ReadData2, 64'h55);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
